pulse_capture: RTL and testbench
================================

# pulse_capture

Capture stage directly downstream of the pulse generator: consumes its 16-sample-per-beat AXI-Stream output and, on a trigger, writes a programmed number of beats into an internal buffer while tracking the signed peak sample. Software reads captured samples back one at a time through a register-style port, which gives loopback verification of generated pulses without a DAC. It sits in parallel with the DAC sink on the same stream.

## Interface
Parameters:
- N, 16, parallel 16-bit samples per beat (fixed by upstream stream width)
- DEPTH, 1024, buffer depth in beats (power of two); AW = log2(DEPTH)

Ports (one clock `aclk`; reset `areset` is synchronous and active-high):
- aclk  in  1  clock for all logic
- areset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tdata  in  N*16  sample i at bits [i*16 +: 16], signed two's complement
- s_axis_tready  out  1  tied 1 (upstream has no backpressure)
- start  in  1  trigger, synchronous to aclk, not re-synced
- START_REG  in  1  software trigger, async, re-synced
- START_SRC_REG  in  1  0: START_REG, 1: start port; async, re-synced
- NWORDS_REG  in  16  beats to capture; 0 = none; >DEPTH clamped to DEPTH
- RD_ADDR_REG  in  AW  readback beat address
- RD_SEL_REG  in  4  readback sample index within beat
- RD_DATA_REG  out  16  readback sample
- COUNT_REG  out  16  beats captured so far
- PEAK_REG  out  16  signed max sample of last capture
- BUSY_REG  out  1  capture or drain in progress
- DONE_REG  out  1  capture complete, results stable

## Operation
- trig_mux = START_SRC_REG_resync ? start : START_REG_resync; trig_rise = trig_mux & ~trig_mux_d.
- States: IDLE, CAPT, DRAIN0, DRAIN1, DONE.
- IDLE: on trig_rise latch nwords_r = min(NWORDS_REG, DEPTH), clear COUNT to 0, preset peak to 16'h8000, clear DONE; go CAPT. If latched nwords_r == 0, go DRAIN0 instead.
- CAPT: each cycle with s_axis_tvalid=1 write s_axis_tdata at address COUNT[AW-1:0], COUNT+1, feed beat into peak tree. When the write makes COUNT == nwords_r go DRAIN0. tvalid=0 cycles write nothing and do not count.
- DRAIN0 -> DRAIN1 -> DONE unconditionally (flush 2-stage peak pipeline).
- DONE: DONE_REG=1; return to IDLE when trig_mux == 0. A trigger held high never re-arms; a new rising edge is required.
- Peak: per beat, signed max of N samples via comparator tree, registered 2 stages; then peak <= max(peak, beat_max). Signed compare: 16'h8000 < 16'h7FFF.
- Trigger edges while in CAPT/DRAIN*/DONE are ignored; deassertion during CAPT does not abort.
- Readback: RD_DATA_REG = mem[RD_ADDR_REG][RD_SEL_REG*16 +: 16]; RD_ADDR/RD_SEL are quasi-static, sampled directly; read any time (reading during CAPT returns old or new data, unspecified).

## Timing
- Reset values: RD_DATA_REG 0, COUNT_REG 0, PEAK_REG 16'h8000, BUSY_REG 0, DONE_REG 0, state IDLE, trig_mux_d 0. Buffer contents not reset.
- Reset mid-capture: IDLE next cycle, all outputs as above.
- START_REG/START_SRC_REG: 2-flop resync (2-cycle latency); start port: direct.
- trig_rise in cycle T -> CAPT in T+1; beat with tvalid in T+1 is the first stored (address 0).
- Last beat written cycle L -> DRAIN0 at L+1, DONE at L+3; PEAK_REG final from L+3.
- BUSY_REG = 1 in CAPT, DRAIN0, DRAIN1.
- Readback latency: 2 cycles from RD_ADDR/RD_SEL change to RD_DATA_REG (BRAM read reg + mux reg).

## Structure
- Shared package pulse_pkg: state enum pulse_capture_state_t, N, SAMPLE_W=16, PEAK_INIT=16'h8000.
- Resync via existing synchronizer_n (its rstn driven by ~areset).
- One natural sub-module: peak_tree (N-input signed max, 2 register stages, no reset needed on data).
- Buffer inferred as simple dual-port BRAM, 1 write / 1 read port, DEPTH x N*16.

## Test plan
- Reset then idle: outputs 0 except PEAK_REG=16'h8000; tvalid beats without trigger -> COUNT stays 0.
- NWORDS=4, start port, continuous beats k=0..9 with sample i = k*16+i -> COUNT=4, DONE 3 cycles after 4th write, RD(addr 3, sel 15)=63, PEAK=63.
- NWORDS=3, tvalid toggling 1,0,1,0,1 -> exactly 3 beats stored at addr 0..2, no gaps.
- Beat containing 16'h8000 and 16'hFFFF only -> PEAK=16'hFFFF (-1); NWORDS=0 -> DONE, COUNT 0, PEAK 16'h8000.
- NWORDS=5000 with DEPTH=1024 -> COUNT stops at 1024; trigger held high after DONE -> no re-arm until low then high.
- Assert areset mid-CAPT (COUNT=7) -> next cycle IDLE, COUNT 0, BUSY 0; START_REG source -> capture begins 3 cycles after START_REG rises.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse capture stage.
// Sample width, peak preset and capture FSM states.
package pulse_pkg;

  localparam int N        = 16;
  localparam int SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] PEAK_INIT = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    DRAIN0,
    DRAIN1,
    DONE
  } pulse_capture_state_t;

  function automatic logic [SAMPLE_W-1:0] smax(
    input logic [SAMPLE_W-1:0] a,
    input logic [SAMPLE_W-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_capture_if.sv
// Sample stream from the pulse generator.
// No backpressure: the slave ties tready high.
interface pulse_axis_if #(
  parameter int W = 256
);
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/pulse_capture_peak_tree.sv
// Signed max over one beat of samples.
// Two register stages; data path carries no reset.
module peak_tree #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic [N*16-1:0] din,
  output logic [15:0]   dmax
);
  import pulse_pkg::*;

  localparam int G = N / 4;

  logic [15:0] s1 [G];
  logic [15:0] s2;

  always_ff @(posedge clk) begin
    for (int g = 0; g < G; g++) begin
      s1[g] <= smax(
        smax(din[(4*g)*16 +: 16],
             din[(4*g+1)*16 +: 16]),
        smax(din[(4*g+2)*16 +: 16],
             din[(4*g+3)*16 +: 16]));
    end
  end

  always_comb begin
    s2 = s1[0];
    for (int g = 1; g < G; g++) begin
      s2 = smax(s2, s1[g]);
    end
  end

  always_ff @(posedge clk) begin
    dmax <= s2;
  end
endmodule

// File: rtl/synchronizer_n.sv
// Two-flop synchronizer for a bundle of quasi-static bits.
// Synchronous active-low reset.
module synchronizer_n #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pulse_capture.sv
// Triggered capture of generator beats into a buffer,
// with signed peak tracking and sample readback.
module pulse_capture #(
  parameter int N     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  pulse_axis_if.slave   s_axis,
  input  logic          start,
  input  logic          START_REG,
  input  logic          START_SRC_REG,
  input  logic [15:0]   NWORDS_REG,
  input  logic [AW-1:0] RD_ADDR_REG,
  input  logic [3:0]    RD_SEL_REG,
  output logic [15:0]   RD_DATA_REG,
  output logic [15:0]   COUNT_REG,
  output logic [15:0]   PEAK_REG,
  output logic          BUSY_REG,
  output logic          DONE_REG
);
  import pulse_pkg::*;

  pulse_capture_state_t state_q, state_d;

  logic [1:0]      sreg_q;
  logic            trig_mux, trig_mux_d;
  logic            trig_rise;
  logic [15:0]     nw_clamp, nwords_r;
  logic [15:0]     count_q;
  logic [15:0]     peak_q;
  logic [15:0]     beat_max;
  logic            wr_en, v1, v2;
  logic [N*16-1:0] mem [DEPTH];
  logic [N*16-1:0] rd_q;
  logic [15:0]     rd_data_q;

  assign s_axis.tready = 1'b1;

  synchronizer_n #(.W(2)) u_sync (
    .clk  (aclk),
    .rstn (~areset),
    .d    ({START_SRC_REG, START_REG}),
    .q    (sreg_q)
  );

  assign trig_mux  = sreg_q[1] ? start : sreg_q[0];
  assign trig_rise = trig_mux & ~trig_mux_d;
  assign nw_clamp  = (NWORDS_REG > 16'(DEPTH))
                   ? 16'(DEPTH) : NWORDS_REG;
  assign wr_en     = (state_q == CAPT) && s_axis.tvalid;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (trig_rise)
          state_d = (nw_clamp == 16'd0) ? DRAIN0 : CAPT;
      CAPT:
        if (wr_en && (count_q + 16'd1 == nwords_r))
          state_d = DRAIN0;
      DRAIN0:  state_d = DRAIN1;
      DRAIN1:  state_d = DONE;
      DONE:
        if (!trig_mux) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY_REG = 1'b0;
    DONE_REG = 1'b0;
    unique case (1'b1)
      (state_q == CAPT),
      (state_q == DRAIN0),
      (state_q == DRAIN1): BUSY_REG = 1'b1;
      (state_q == DONE):   DONE_REG = 1'b1;
      default: ;
    endcase
  end

  peak_tree #(.N(N)) u_peak (
    .clk  (aclk),
    .din  (s_axis.tdata),
    .dmax (beat_max)
  );

  // v1/v2 follow each stored beat through the tree
  always_ff @(posedge aclk) begin
    if (areset) begin
      trig_mux_d <= 1'b0;
      nwords_r   <= '0;
      count_q    <= '0;
      peak_q     <= PEAK_INIT;
      v1         <= 1'b0;
      v2         <= 1'b0;
    end else begin
      trig_mux_d <= trig_mux;
      v1         <= wr_en;
      v2         <= v1;
      if (state_q == IDLE && trig_rise) begin
        nwords_r <= nw_clamp;
        count_q  <= '0;
        peak_q   <= PEAK_INIT;
      end else begin
        if (wr_en) count_q <= count_q + 16'd1;
        if (v2) peak_q <= smax(peak_q, beat_max);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[count_q[AW-1:0]] <= s_axis.tdata;
    rd_q <= mem[RD_ADDR_REG];
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_data_q <= '0;
    else rd_data_q <= rd_q[{RD_SEL_REG, 4'b0000} +: 16];
  end

  assign RD_DATA_REG = rd_data_q;
  assign COUNT_REG   = count_q;
  assign PEAK_REG    = peak_q;
endmodule

// File: tb/tb_pulse_capture.sv
// Randomized bench for pulse_capture against a
// beat-list reference model.
module tb_pulse_capture;
  localparam int N     = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BW    = N * 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          START_REG = 1'b0;
  logic          START_SRC_REG = 1'b1;
  logic [15:0]   NWORDS_REG = '0;
  logic [AW-1:0] RD_ADDR_REG = '0;
  logic [3:0]    RD_SEL_REG = '0;
  logic [15:0]   RD_DATA_REG, COUNT_REG, PEAK_REG;
  logic          BUSY_REG, DONE_REG;

  int checks = 0;
  int failures = 0;

  pulse_axis_if #(.W(BW)) axis ();

  always #5 aclk = ~aclk;

  pulse_capture #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis        (axis),
    .start         (start),
    .START_REG     (START_REG),
    .START_SRC_REG (START_SRC_REG),
    .NWORDS_REG    (NWORDS_REG),
    .RD_ADDR_REG   (RD_ADDR_REG),
    .RD_SEL_REG    (RD_SEL_REG),
    .RD_DATA_REG   (RD_DATA_REG),
    .COUNT_REG     (COUNT_REG),
    .PEAK_REG      (PEAK_REG),
    .BUSY_REG      (BUSY_REG),
    .DONE_REG      (DONE_REG)
  );

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    for (int i = 0; i < N; i++) b[i*16 +: 16] = 16'($urandom);
    return b;
  endfunction

  task automatic rd(input int a, input int s,
                    output logic [15:0] v);
    @(negedge aclk);
    RD_ADDR_REG = a[AW-1:0];
    RD_SEL_REG  = s[3:0];
    @(negedge aclk);
    @(negedge aclk);
    v = RD_DATA_REG;
  endtask

  // mode 0 random, 1 counting, 2 toggling valid, 3 min/-1 mix
  task automatic run_capture(input int nw, input int mode,
                             input bit hold, input string nm);
    logic [BW-1:0] q[$];
    logic [BW-1:0] d;
    logic signed [15:0] pk;
    logic [15:0] v16, ev;
    int need, k, a, s;
    bit v;
    need = (nw > DEPTH) ? DEPTH : nw;
    pk = 16'sh8000;
    @(negedge aclk);
    NWORDS_REG = 16'(nw);
    start = 1'b1;
    axis.tvalid = 1'b0;
    axis.tdata = rand_beat();
    @(negedge aclk);
    if (!hold) start = 1'b0;
    checks++;
    if (BUSY_REG !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_start got=%b exp=1", nm, BUSY_REG);
    end
    k = 0;
    while (q.size() < need) begin
      case (mode)
        1: begin
          v = 1'b1;
          for (int i = 0; i < N; i++) d[i*16 +: 16] = 16'(k*16 + i);
        end
        2: begin
          v = (k % 2 == 0);
          d = rand_beat();
        end
        3: begin
          v = 1'b1;
          for (int i = 0; i < N; i++)
            d[i*16 +: 16] = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
        end
        default: begin
          v = ($urandom_range(0, 3) != 0);
          d = rand_beat();
        end
      endcase
      axis.tvalid = v;
      axis.tdata = d;
      if (v) begin
        q.push_back(d);
        for (int i = 0; i < N; i++)
          if ($signed(d[i*16 +: 16]) > pk) pk = d[i*16 +: 16];
      end
      @(negedge aclk);
      k++;
    end
    for (int c = 0; c < 2; c++) begin
      axis.tvalid = 1'b1;
      axis.tdata = rand_beat();
      checks++;
      if (BUSY_REG !== 1'b1 || DONE_REG !== 1'b0) begin
        failures++;
        $display("FAIL %s_drain%0d busy=%b done=%b exp busy=1 done=0",
                 nm, c, BUSY_REG, DONE_REG);
      end
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    checks++;
    if (DONE_REG !== 1'b1 || BUSY_REG !== 1'b0) begin
      failures++;
      $display("FAIL %s_done done=%b busy=%b exp done=1 busy=0",
               nm, DONE_REG, BUSY_REG);
    end
    checks++;
    if (COUNT_REG !== 16'(need)) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, COUNT_REG, need);
    end
    checks++;
    if (PEAK_REG !== pk) begin
      failures++;
      $display("FAIL %s_peak got=%h exp=%h", nm, PEAK_REG, pk);
    end
    if (need > 0) begin
      for (int j = 0; j < 3; j++) begin
        a = (j == 0) ? need - 1 : $urandom_range(0, need - 1);
        s = $urandom_range(0, 15);
        rd(a, s, v16);
        ev = q[a][s*16 +: 16];
        checks++;
        if (v16 !== ev) begin
          failures++;
          $display("FAIL %s_rd a=%0d s=%0d got=%h exp=%h",
                   nm, a, s, v16, ev);
        end
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    axis.tvalid = 1'b0;
    axis.tdata = '0;
    repeat (3) @(negedge aclk);
    checks++;
    if (RD_DATA_REG !== 16'h0 || COUNT_REG !== 16'h0 ||
        PEAK_REG !== 16'h8000 || BUSY_REG !== 1'b0 ||
        DONE_REG !== 1'b0 || axis.tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_vals rd=%h cnt=%h pk=%h b=%b d=%b r=%b exp 0 0 8000 0 0 1",
               RD_DATA_REG, COUNT_REG, PEAK_REG,
               BUSY_REG, DONE_REG, axis.tready);
    end
    areset = 1'b0;
    NWORDS_REG = 16'd8;
    for (int i = 0; i < 6; i++) begin
      axis.tvalid = 1'b1;
      axis.tdata = rand_beat();
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    checks++;
    if (COUNT_REG !== 16'h0 || BUSY_REG !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_trig cnt=%0d busy=%b exp 0 0",
               COUNT_REG, BUSY_REG);
    end
  endtask

  task automatic test_counting();
    logic [15:0] v16;
    run_capture(4, 1, 1'b0, "count4");
    rd(3, 15, v16);
    checks++;
    if (v16 !== 16'd63) begin
      failures++;
      $display("FAIL count4_rd3_15 got=%0d exp=63", v16);
    end
    checks++;
    if (PEAK_REG !== 16'd63) begin
      failures++;
      $display("FAIL count4_peak got=%0d exp=63", PEAK_REG);
    end
  endtask

  task automatic test_toggle();
    run_capture(3, 2, 1'b0, "toggle3");
  endtask

  task automatic test_peak_neg();
    run_capture(1, 3, 1'b0, "neg");
    checks++;
    if (PEAK_REG !== 16'hFFFF) begin
      failures++;
      $display("FAIL neg_peak got=%h exp=ffff", PEAK_REG);
    end
    run_capture(0, 0, 1'b0, "zero");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_capture($urandom_range(1, 40), 0, 1'b0, "rand");
  endtask

  task automatic test_clamp_rearm();
    run_capture(5000, 0, 1'b1, "clamp");
    repeat (4) @(negedge aclk);
    checks++;
    if (DONE_REG !== 1'b1 || BUSY_REG !== 1'b0 ||
        COUNT_REG !== 16'd1024) begin
      failures++;
      $display("FAIL held_no_rearm done=%b busy=%b cnt=%0d exp 1 0 1024",
               DONE_REG, BUSY_REG, COUNT_REG);
    end
    start = 1'b0;
    @(negedge aclk);
    checks++;
    if (DONE_REG !== 1'b0) begin
      failures++;
      $display("FAIL release_idle done=%b exp=0", DONE_REG);
    end
    NWORDS_REG = 16'd2;
    start = 1'b1;
    @(negedge aclk);
    checks++;
    if (BUSY_REG !== 1'b1) begin
      failures++;
      $display("FAIL rearm_busy got=%b exp=1", BUSY_REG);
    end
    axis.tvalid = 1'b1;
    repeat (6) begin
      axis.tdata = rand_beat();
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    start = 1'b0;
    checks++;
    if (COUNT_REG !== 16'd2) begin
      failures++;
      $display("FAIL rearm_count got=%0d exp=2", COUNT_REG);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    NWORDS_REG = 16'd20;
    start = 1'b1;
    axis.tvalid = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    axis.tvalid = 1'b1;
    repeat (7) begin
      axis.tdata = rand_beat();
      @(negedge aclk);
    end
    checks++;
    if (COUNT_REG !== 16'd7 || BUSY_REG !== 1'b1) begin
      failures++;
      $display("FAIL mid_count cnt=%0d busy=%b exp 7 1",
               COUNT_REG, BUSY_REG);
    end
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (COUNT_REG !== 16'h0 || BUSY_REG !== 1'b0 ||
        DONE_REG !== 1'b0 || PEAK_REG !== 16'h8000 ||
        RD_DATA_REG !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset cnt=%h b=%b d=%b pk=%h rd=%h exp 0 0 0 8000 0",
               COUNT_REG, BUSY_REG, DONE_REG, PEAK_REG, RD_DATA_REG);
    end
    areset = 1'b0;
    axis.tvalid = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_start_reg();
    START_SRC_REG = 1'b0;
    repeat (4) @(negedge aclk);
    NWORDS_REG = 16'd2;
    START_REG = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge aclk);
      checks++;
      if (BUSY_REG !== (c == 3)) begin
        failures++;
        $display("FAIL startreg_lat c=%0d busy=%b exp=%b",
                 c, BUSY_REG, (c == 3));
      end
    end
    axis.tvalid = 1'b1;
    repeat (5) begin
      axis.tdata = rand_beat();
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    checks++;
    if (COUNT_REG !== 16'd2 || DONE_REG !== 1'b1) begin
      failures++;
      $display("FAIL startreg_cap cnt=%0d done=%b exp 2 1",
               COUNT_REG, DONE_REG);
    end
    START_REG = 1'b0;
    START_SRC_REG = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata = '0;
    test_reset();
    test_counting();
    test_toggle();
    test_peak_neg();
    test_random();
    test_clamp_rearm();
    test_reset_mid();
    test_start_reg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
